// File: rtl/inst_mem_loader_pkg.sv
// inst_mem_loader_pkg: shared state encoding, constants and byte-lane helper for the instruction-memory loader
package inst_mem_loader_pkg;
   localparam int LEN_W = 16;
   localparam int DEF_ADDR_STEP = 4;
   localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0000;
   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_WRITE,
`ifdef LOADER_CHECKSUM_EN
      S_CHECK,
`endif
      S_FIN
   } state_t;
   function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] k, input logic [7:0] b);
      logic [31:0] r;
      r = w;
      r[8*k +: 8] = b;
      return r;
   endfunction
endpackage

// File: rtl/ld_word_assembler.sv
// ld_word_assembler: packs accepted bytes little-endian into a 32-bit word and flags the fourth byte
module ld_word_assembler
   import inst_mem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        accept,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic [1:0]  byte_idx,
   output logic        word_full
);
   assign word_full = accept && (byte_idx == 2'd3);
   // Byte k of the word lands in lane k; the index wraps after the fourth byte.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word <= '0;
         byte_idx <= '0;
      end else if (clr) begin
         word <= '0;
         byte_idx <= '0;
      end else if (accept) begin
         word <= put_byte(word, byte_idx, byte_in);
         byte_idx <= byte_idx + 2'd1;
      end
   end
endmodule

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: streams a length-prefixed program into instruction memory; LOADER_CHECKSUM_EN adds a trailing XOR check byte
module inst_mem_loader
   import inst_mem_loader_pkg::*;
#(
   parameter int          MAX_WORDS = 256,
   parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
   parameter int          ADDR_STEP = DEF_ADDR_STEP
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        cpu_hold,
   output logic [15:0] word_count
);
   state_t state, state_nx;
   logic [LEN_W-1:0] n;
   logic [LEN_W-1:0] n_in;
   logic xfer, ld_start, fin_ok, fin_err, step, word_full, last_word;
   logic [1:0] byte_idx;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0] csum;
   assign byte_ready = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA) || (state == S_CHECK);
`else
   assign byte_ready = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA);
`endif
   assign xfer = byte_valid && byte_ready;
   assign wr_en = state == S_WRITE;
   assign busy = (state != S_IDLE) && (state != S_FIN);
   assign n_in = {byte_in, n[7:0]};
   assign last_word = (word_count + 16'd1) == n;

   ld_word_assembler u_asm (
      .clk(clk),
      .reset(reset),
      .clr(ld_start),
      .accept(xfer && (state == S_DATA)),
      .byte_in(byte_in),
      .word(wr_data),
      .byte_idx(byte_idx),
      .word_full(word_full)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else state <= state_nx;
   end

   // Next state plus the one-cycle strobes that drive the datapath.
   always_comb begin
      state_nx = state;
      ld_start = 1'b0;
      fin_ok = 1'b0;
      fin_err = 1'b0;
      step = 1'b0;
      case (state)
         S_IDLE, S_FIN: if (start) begin
            state_nx = S_LEN_LO;
            ld_start = 1'b1;
         end
         S_LEN_LO: if (xfer) state_nx = S_LEN_HI;
         S_LEN_HI: if (xfer) begin
            if (n_in == '0) begin
`ifdef LOADER_CHECKSUM_EN
               state_nx = S_CHECK;
`else
               state_nx = S_FIN;
               fin_ok = 1'b1;
`endif
            end else if (n_in > LEN_W'(MAX_WORDS)) begin
               state_nx = S_FIN;
               fin_err = 1'b1;
            end else state_nx = S_DATA;
         end
         S_DATA: if (word_full) state_nx = S_WRITE;
         S_WRITE: begin
            step = 1'b1;
            if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
               state_nx = S_CHECK;
`else
               state_nx = S_FIN;
               fin_ok = 1'b1;
`endif
            end else state_nx = S_DATA;
         end
`ifdef LOADER_CHECKSUM_EN
         S_CHECK: if (xfer) begin
            state_nx = S_FIN;
            fin_ok = byte_in == csum;
            fin_err = byte_in != csum;
         end
`endif
         default: state_nx = S_IDLE;
      endcase
   end

   // Length header, write address, word counter and sticky status flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         n <= '0;
         wr_addr <= BASE_ADDR;
         word_count <= '0;
         done <= 1'b0;
         error <= 1'b0;
         cpu_hold <= 1'b1;
      end else begin
         if (ld_start) begin
            wr_addr <= BASE_ADDR;
            word_count <= '0;
            done <= 1'b0;
            error <= 1'b0;
            cpu_hold <= 1'b1;
         end
         if (xfer && (state == S_LEN_LO)) n[7:0] <= byte_in;
         if (xfer && (state == S_LEN_HI)) n[15:8] <= byte_in;
         if (step) begin
            wr_addr <= wr_addr + 32'(ADDR_STEP);
            word_count <= word_count + 16'd1;
         end
         if (fin_ok) begin
            done <= 1'b1;
            cpu_hold <= 1'b0;
         end
         if (fin_err) error <= 1'b1;
      end
   end

`ifdef LOADER_CHECKSUM_EN
   // Running XOR of every data byte, compared against the trailing check byte.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) csum <= '0;
      else if (ld_start) csum <= '0;
      else if (xfer && (state == S_DATA)) csum <= csum ^ byte_in;
   end
`endif

   // A WRITE cycle always follows a complete four-byte word.
   assert property (@(posedge clk) disable iff (reset) (state == S_WRITE) |-> (byte_idx == 2'd0));
endmodule
